// File: rtl/siso_lane_arbiter.sv
// Two-requester round-robin arbiter feeding one MSB-first serial lane with a frame strobe.
// Latency: first bit appears on the accept edge; each word holds the lane WIDTH+GAP+1 cycles.
// Backpressure: ready is offered only while idle; a requester waits or withdraws while the lane is busy.
module siso_lane_arbiter #(
   parameter int WIDTH = 8,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             serial_out,
   output logic             frame,
   output logic             owner,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             last_owner;
   logic             grant_vld;
   logic             grant_idx;
   logic [WIDTH-1:0] grant_dat;

   // Reset blocks the grant so no handshake can complete on a reset edge.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 1'b0;
      if (state == ST_IDLE && !reset) begin
         if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_idx = ~last_owner;
         end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_idx = 1'b0;
         end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_idx = 1'b1;
         end
      end
   end

   assign req0_ready = grant_vld && !grant_idx;
   assign req1_ready = grant_vld &&  grant_idx;
   assign grant_dat  = grant_idx ? req1_data : req0_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         last_owner <= 1'b1;
         serial_out <= 1'b0;
         frame      <= 1'b0;
         done       <= 1'b0;
         owner      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_vld) begin
                  serial_out <= grant_dat[WIDTH-1];
                  shreg      <= grant_dat << 1;
                  bit_cnt    <= CW'(WIDTH - 1);
                  frame      <= 1'b1;
                  owner      <= grant_idx;
                  last_owner <= grant_idx;
                  state      <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (bit_cnt != '0) begin
                  serial_out <= shreg[WIDTH-1];
                  shreg      <= shreg << 1;
                  bit_cnt    <= bit_cnt - 1'b1;
               end else begin
                  frame      <= 1'b0;
                  serial_out <= 1'b0;
                  done       <= 1'b1;
                  if (GAP > 0) begin
                     state   <= ST_GAP;
                     gap_cnt <= GW'(GAP - 1);
                  end else begin
                     state   <= ST_IDLE;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) state <= ST_IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
